// File: rtl/rbz_spi_regs_pkg.sv
// Shared definitions for the SPI-loaded double-buffered register bank:
// default geometry, FSM state encodings and the header bit layout.
package rbz_spi_regs_pkg;

  localparam int DEF_NUM_REGS = 6;
  localparam int DEF_REG_W    = 16;
  localparam int DEF_ADDR_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } spi_state_e;

  // Header is the WE bit followed by the address, MSB first.
  function automatic int hdr_bits(input int addr_w);
    return addr_w + 1;
  endfunction

  // After the whole header is shifted in, WE sits just above the address field.
  function automatic int hdr_we_pos(input int addr_w);
    return addr_w;
  endfunction

endpackage

// File: rtl/rbz_spi_regs_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain through 2-FF
// synchronisers and derives sclk edge pulses and the ss_n falling-edge pulse
// from a third stage. mosi is delayed by the same two stages so it stays
// aligned with the synchronised sclk rise.
module rbz_spi_regs_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic sclk_i,
  input  logic mosi_i,
  input  logic ss_n_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic mosi_o,
  output logic ss_n_o,
  output logic ss_n_fall_o
);

  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  logic [2:0] ss_n_q;

  // Synchroniser and edge-detect shift chains; ss_n resets to its idle level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q <= '0;
      mosi_q <= '0;
      ss_n_q <= '1;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      mosi_q <= {mosi_q[0], mosi_i};
      ss_n_q <= {ss_n_q[1:0], ss_n_i};
    end
  end

  assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_o = ~sclk_q[1] & sclk_q[2];
  assign mosi_o      = mosi_q[1];
  assign ss_n_o      = ss_n_q[1];
  assign ss_n_fall_o = ~ss_n_q[1] & ss_n_q[2];

endmodule

// File: rtl/rbz_spi_regs.sv
// SPI-loaded, double-buffered register bank. Host bursts land in a shadow
// bank; dirty shadow registers move to the live bank only on load_if_ready
// while no frame is in progress, so consumers never see a torn update.
// Optional readback: define RBZ_SPI_MISO_EN to shift live[addr] out on o_miso.
//
// state   | meaning
// ST_IDLE | no frame; commits allowed here only
// ST_HDR  | shifting in WE + address
// ST_DATA | shifting in REG_W-bit words, address auto-increments
module rbz_spi_regs
  import rbz_spi_regs_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_W    = DEF_REG_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter logic [NUM_REGS*REG_W-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_sclk,
  input  logic                      i_mosi,
  input  logic                      i_ss_n,
  input  logic                      load_if_ready,
  output logic [NUM_REGS*REG_W-1:0] o_regs,
  output logic                      o_pending,
  output logic                      o_loaded,
  output logic                      o_miso
);

  localparam int HDR_BITS = hdr_bits(ADDR_W);
  localparam int WE_POS   = hdr_we_pos(ADDR_W);
  localparam int CNT_MAX  = (REG_W > HDR_BITS) ? REG_W : HDR_BITS;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  logic sclk_rise, sclk_fall, mosi_s, ss_n_s, ss_n_fall;

  rbz_spi_regs_sync_edge u_sync (
    .clk         (clk),
    .reset_n     (reset_n),
    .sclk_i      (i_sclk),
    .mosi_i      (i_mosi),
    .ss_n_i      (i_ss_n),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .mosi_o      (mosi_s),
    .ss_n_o      (ss_n_s),
    .ss_n_fall_o (ss_n_fall)
  );

  spi_state_e                      state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [REG_W-2:0]                shift_q, shift_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic                            we_q, we_d;
  logic [NUM_REGS-1:0][REG_W-1:0]  shadow_q, shadow_d;
  logic [NUM_REGS-1:0][REG_W-1:0]  live_q, live_d;
  logic [NUM_REGS-1:0]             dirty_q, dirty_d;
  logic                            loaded_q, loaded_d;

  logic [REG_W-1:0] shift_nxt;
  logic             hdr_done, word_done;

  // Only REG_W-1 bits are stored; the bit arriving now completes the word.
  assign shift_nxt = {shift_q, mosi_s};
  assign hdr_done  = (state_q == ST_HDR) && !ss_n_s && sclk_rise &&
                     (cnt_q == CNT_W'(HDR_BITS - 1));
  assign word_done = (state_q == ST_DATA) && !ss_n_s && sclk_rise &&
                     (cnt_q == CNT_W'(REG_W - 1));

  // Next-state logic: frame parsing, shadow writes and the commit to live.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    addr_d   = addr_q;
    we_d     = we_q;
    shadow_d = shadow_q;
    live_d   = live_q;
    dirty_d  = dirty_q;
    loaded_d = 1'b0;

    if (ss_n_s) begin
      // Deselect aborts any partial header/word; only IDLE may commit.
      state_d = ST_IDLE;
      cnt_d   = '0;
      if ((state_q == ST_IDLE) && load_if_ready && (|dirty_q)) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (dirty_q[k]) live_d[k] = shadow_q[k];
        end
        dirty_d  = '0;
        loaded_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ss_n_fall) state_d = ST_HDR;
        end
        ST_HDR: begin
          if (sclk_rise) begin
            shift_d = shift_nxt[REG_W-2:0];
            if (hdr_done) begin
              we_d    = shift_nxt[WE_POS];
              addr_d  = shift_nxt[ADDR_W-1:0];
              cnt_d   = '0;
              state_d = ST_DATA;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            shift_d = shift_nxt[REG_W-2:0];
            if (word_done) begin
              cnt_d = '0;
              if (we_q) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                  if (addr_q == ADDR_W'(k)) begin
                    shadow_d[k] = shift_nxt;
                    dirty_d[k]  = 1'b1;
                  end
                end
              end
              addr_d = addr_q + ADDR_W'(1);
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      shadow_q <= RESET_VAL;
      live_q   <= RESET_VAL;
      dirty_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      shadow_q <= shadow_d;
      live_q   <= live_d;
      dirty_q  <= dirty_d;
      loaded_q <= loaded_d;
    end
  end

  assign o_regs    = live_q;
  assign o_pending = |dirty_q;
  assign o_loaded  = loaded_q;

`ifdef RBZ_SPI_MISO_EN
  logic [REG_W-1:0] rd_sh_q, rd_sh_d;
  logic [REG_W-1:0] rd_word;
  logic             miso_q, miso_d;

  // Readback: load live[next addr] at each header/word boundary, shift on sclk fall.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr_d == ADDR_W'(k)) rd_word = live_q[k];
    end
    rd_sh_d = rd_sh_q;
    miso_d  = miso_q;
    if (state_d != ST_DATA) begin
      rd_sh_d = '0;
      miso_d  = 1'b0;
    end else if (hdr_done || word_done) begin
      rd_sh_d = rd_word;
    end else if (sclk_fall) begin
      miso_d  = rd_sh_q[REG_W-1];
      rd_sh_d = {rd_sh_q[REG_W-2:0], 1'b0};
    end
  end

  // Readback shifter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sh_q <= '0;
      miso_q  <= 1'b0;
    end else begin
      rd_sh_q <= rd_sh_d;
      miso_q  <= miso_d;
    end
  end

  assign o_miso = miso_q;
`else
  logic unused_sclk_fall;
  assign unused_sclk_fall = sclk_fall;
  assign o_miso           = 1'b0;
`endif

endmodule

// File: tb/tb_rbz_spi_regs.sv
// Directed bench for rbz_spi_regs: 6 x 16-bit bank, reg k resets to 16'h0100*k,
// SPI clock at clk/8. Expected live/shadow state is kept in a small model.
module tb_rbz_spi_regs;

  localparam logic [95:0] RV = {16'h0500, 16'h0400, 16'h0300,
                                16'h0200, 16'h0100, 16'h0000};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_sclk, i_mosi, i_ss_n, load_if_ready;
  logic [95:0] o_regs;
  logic        o_pending, o_loaded, o_miso;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] live_m [6];
  logic [15:0] sh_m   [6];
  logic [5:0]  dirty_m;
  logic [15:0] rd_cap;
  logic        l1, l2;
  logic [15:0] exp_rd;

  rbz_spi_regs #(
    .NUM_REGS (6),
    .REG_W    (16),
    .ADDR_W   (3),
    .RESET_VAL(RV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_sclk       (i_sclk),
    .i_mosi       (i_mosi),
    .i_ss_n       (i_ss_n),
    .load_if_ready(load_if_ready),
    .o_regs       (o_regs),
    .o_pending    (o_pending),
    .o_loaded     (o_loaded),
    .o_miso       (o_miso)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin
      live_m[k] = 16'(k << 8);
      sh_m[k]   = 16'(k << 8);
    end
    dirty_m = '0;
  endtask

  task automatic model_write(input int a, input logic [15:0] d);
    if (a < 6) begin
      sh_m[a]    = d;
      dirty_m[a] = 1'b1;
    end
  endtask

  task automatic model_commit();
    for (int k = 0; k < 6; k++) if (dirty_m[k]) live_m[k] = sh_m[k];
    dirty_m = '0;
  endtask

  function automatic logic [95:0] live_flat();
    logic [95:0] f;
    for (int k = 0; k < 6; k++) f[k*16 +: 16] = live_m[k];
    return f;
  endfunction

  // Mode 0: drive mosi while sclk low, host samples miso just before the rise.
  task automatic spi_bit(input logic b, output logic so);
    i_mosi = b;
    #40;
    so = o_miso;
    i_sclk = 1'b1;
    #40;
    i_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    logic so;
    rd_cap = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(w[i], so);
      rd_cap = {rd_cap[14:0], so};
    end
  endtask

  task automatic send_hdr(input logic we, input logic [2:0] a);
    send_bits({12'h000, we, a}, 4);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    i_ss_n = 1'b0;
    #40;
  endtask

  task automatic frame_end();
    #40;
    i_ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic strobe(output logic s1, output logic s2);
    @(negedge clk);
    load_if_ready = 1'b1;
    @(negedge clk);
    load_if_ready = 1'b0;
    s1 = o_loaded;
    @(negedge clk);
    s2 = o_loaded;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; i_sclk = 1'b0; i_mosi = 1'b0; i_ss_n = 1'b1; load_if_ready = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    model_reset();
    chk("reset_regs", o_regs, RV);
    chk("reset_pending", o_pending, 1'b0);
    chk("reset_loaded", o_loaded, 1'b0);
    chk("reset_miso", o_miso, 1'b0);

    // Single write, held until strobe
    frame_begin(); send_hdr(1'b1, 3'd2); send_bits(16'h1234, 16); frame_end();
    model_write(2, 16'h1234);
    chk("wr2_regs_held", o_regs, live_flat());
    chk("wr2_pending", o_pending, 1'b1);
    chk("wr2_no_loaded", o_loaded, 1'b0);
    strobe(l1, l2); model_commit();
    chk("wr2_loaded_pulse", l1, 1'b1);
    chk("wr2_loaded_1clk", l2, 1'b0);
    chk("wr2_regs", o_regs, live_flat());
    chk("wr2_pending_clr", o_pending, 1'b0);

    // Burst running past the last register
    frame_begin(); send_hdr(1'b1, 3'd4);
    send_bits(16'hAAAA, 16); send_bits(16'hBBBB, 16);
    send_bits(16'hCCCC, 16); send_bits(16'hDDDD, 16);
    frame_end();
    model_write(4, 16'hAAAA); model_write(5, 16'hBBBB);
    model_write(6, 16'hCCCC); model_write(7, 16'hDDDD);
    strobe(l1, l2); model_commit();
    chk("burst_loaded", l1, 1'b1);
    chk("burst_regs", o_regs, live_flat());

    // Partial word discarded
    frame_begin(); send_hdr(1'b1, 3'd0); send_bits(16'h03FF, 10); frame_end();
    chk("partial_pending", o_pending, 1'b0);
    strobe(l1, l2);
    chk("partial_loaded", l1, 1'b0);
    chk("partial_reg0", o_regs[15:0], 16'h0000);

    // Strobe inside a frame is ignored
    frame_begin(); send_hdr(1'b1, 3'd0); send_bits(16'h5A5A, 16);
    model_write(0, 16'h5A5A);
    strobe(l1, l2);
    chk("inframe_loaded", l1, 1'b0);
    chk("inframe_loaded2", l2, 1'b0);
    chk("inframe_regs", o_regs, live_flat());
    frame_end();
    chk("inframe_pending", o_pending, 1'b1);
    strobe(l1, l2); model_commit();
    chk("afterframe_loaded", l1, 1'b1);
    chk("afterframe_regs", o_regs, live_flat());

    // Last write wins across two frames
    frame_begin(); send_hdr(1'b1, 3'd5); send_bits(16'h1111, 16); frame_end();
    frame_begin(); send_hdr(1'b1, 3'd5); send_bits(16'h2222, 16); frame_end();
    model_write(5, 16'h1111); model_write(5, 16'h2222);
    strobe(l1, l2); model_commit();
    chk("rewrite_regs", o_regs, live_flat());

    // WE=0 writes nothing; strobe with nothing dirty is a no-op
    frame_begin(); send_hdr(1'b0, 3'd1); send_bits(16'hFFFF, 16); frame_end();
    chk("read_pending", o_pending, 1'b0);
    strobe(l1, l2);
    chk("read_no_loaded", l1, 1'b0);
    chk("read_regs", o_regs, live_flat());

    // Address wraps 7 -> 0
    frame_begin(); send_hdr(1'b1, 3'd7);
    send_bits(16'h0001, 16); send_bits(16'hC0DE, 16);
    frame_end();
    model_write(7, 16'h0001); model_write(0, 16'hC0DE);
    strobe(l1, l2); model_commit();
    chk("wrap_regs", o_regs, live_flat());

    // Reset in the middle of a frame with a dirty shadow register
    frame_begin(); send_hdr(1'b1, 3'd3); send_bits(16'h7777, 16); send_bits(16'h00FF, 8);
    reset_n = 1'b0;
    #40;
    i_ss_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    model_reset();
    chk("midrst_regs", o_regs, RV);
    chk("midrst_pending", o_pending, 1'b0);
    chk("midrst_loaded", o_loaded, 1'b0);
    frame_begin(); send_hdr(1'b1, 3'd1); send_bits(16'hBEEF, 16); frame_end();
    model_write(1, 16'hBEEF);
    strobe(l1, l2); model_commit();
    chk("postrst_loaded", l1, 1'b1);
    chk("postrst_regs", o_regs, live_flat());

    // Readback of reg3 (tied-low output when readback is not built)
`ifdef RBZ_SPI_MISO_EN
    exp_rd = 16'h0300;
`else
    exp_rd = 16'h0000;
`endif
    frame_begin(); send_hdr(1'b0, 3'd3); send_bits(16'h0000, 16); frame_end();
    chk("miso_stream", rd_cap, exp_rd);
    chk("miso_regs", o_regs, live_flat());
    chk("miso_pending", o_pending, 1'b0);
    chk("miso_idle", o_miso, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
